// File: rtl/nic_defs.sv
// Shared NIC type definitions used by the RX path, the flow dispatcher and the
// CCI-P transmitter.
//   RpcIf  : RPC descriptor carried between the network and the transmitter.
//   FlowId : TX flow identifier (sized for the largest supported flow count).
//   ConnId : 16-bit connection identifier.
package nic_defs;

    localparam int unsigned LMAX_CCIP_BATCH     = 2;
    localparam int unsigned LMAX_CCIP_DMA_BATCH = 2;
    localparam int unsigned LMAX_FLOW_ID_WIDTH  = 8;
    localparam int unsigned CONN_ID_WIDTH       = 16;

    typedef struct packed {
        logic [31:0] rpc_id;
        logic [15:0] method_id;
        logic [7:0]  arg_len;
        logic [7:0]  flags;
    } RpcIf;

    typedef logic [LMAX_FLOW_ID_WIDTH-1:0] FlowId;
    typedef logic [CONN_ID_WIDTH-1:0]      ConnId;

endpackage

// File: rtl/flow_dispatch_fifo.sv
// Synchronous FIFO with first-word-fall-through read and an occupancy count.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data : push; caller guarantees no push while full
//   rd_en          : pop; caller guarantees no pop while empty
//   rd_data_c      : head entry, valid whenever count != 0
//   count          : number of stored entries (0 .. 2^LSIZE)
module flow_dispatch_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LSIZE      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    output logic [LSIZE:0]        count
);

    localparam int unsigned DEPTH = 1 << LSIZE;
    localparam int unsigned PTR_W = LSIZE;
    localparam int unsigned CNT_W = LSIZE + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage array; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/rpc_flow_dispatcher.sv
// Ingress stage ahead of the CCI-P transmitter: tags each accepted RPC with a
// TX flow ID, buffers it, and drains one RPC per cycle while the transmitter
// is ready. RPCs offered while the buffer is full are dropped and counted.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : enables ingress and egress
//   number_of_flows       : highest valid flow index (N-1)
//   lb_mode               : 0 = round-robin, 1 = static by connection ID
//   net_rpc_in/_valid_in  : RPC from the network, with its connection ID
//   net_conn_id_in
//   net_ready_out         : buffer has room this cycle
//   ccip_tx_ready         : transmitter can take an RPC
//   rpc_out, rpc_valid_out, rpc_flow_id_out : RPC toward the transmitter
//   dispatched_cnt_out    : RPCs delivered (wraps)
//   drop_cnt_out          : RPCs dropped at ingress (wraps)
module rpc_flow_dispatcher
    import nic_defs::*;
#(
    parameter int unsigned NIC_ID            = 0,
    parameter int unsigned LMAX_NUM_OF_FLOWS = 1,
    parameter int unsigned LFIFO_DEPTH       = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
    input  logic                          lb_mode,
    input  logic [$bits(RpcIf)-1:0]       net_rpc_in,
    input  logic                          net_rpc_valid_in,
    input  logic [15:0]                   net_conn_id_in,
    output logic                          net_ready_out,
    input  logic                          ccip_tx_ready,
    output logic [$bits(RpcIf)-1:0]       rpc_out,
    output logic                          rpc_valid_out,
    output logic [LMAX_NUM_OF_FLOWS-1:0]  rpc_flow_id_out,
    output logic [31:0]                   dispatched_cnt_out,
    output logic [31:0]                   drop_cnt_out
);

    localparam int unsigned RPC_W  = $bits(RpcIf);
    localparam int unsigned FLOW_W = LMAX_NUM_OF_FLOWS;
    localparam int unsigned DATA_W = RPC_W + FLOW_W;
    localparam int unsigned CNT_W  = LFIFO_DEPTH + 1;
    localparam int unsigned OCC_W  = LFIFO_DEPTH + 2;
    localparam int unsigned DEPTH  = 1 << LFIFO_DEPTH;

    logic              stage_valid;
    logic [RPC_W-1:0]  stage_rpc;
    logic [FLOW_W-1:0] stage_flow;
    logic [FLOW_W-1:0] rr_ptr;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic              accept;
    logic              drop;
    logic              push;
    logic              pop;
    logic [FLOW_W-1:0] flow_sel;
    logic [FLOW_W-1:0] rr_next;
    logic [CNT_W-1:0]  count_next;
    logic [OCC_W-1:0]  occ_next;

    // Handshake decode, flow selection and next-state occupancy.
    always_comb begin
        accept     = start & net_rpc_valid_in & net_ready_out;
        drop       = start & net_rpc_valid_in & ~net_ready_out;
        push       = stage_valid;
        pop        = start & ccip_tx_ready & (fifo_count != '0);
        flow_sel   = '0;
        rr_next    = rr_ptr;

        if (lb_mode) begin
            flow_sel = FLOW_W'(net_conn_id_in & ConnId'(number_of_flows));
        end else if (rr_ptr > number_of_flows) begin
            // Flow count shrank under a live pointer: restart from flow 0.
            flow_sel = '0;
            rr_next  = (number_of_flows == '0) ? '0 : FLOW_W'(1);
        end else begin
            flow_sel = rr_ptr;
            rr_next  = (rr_ptr == number_of_flows) ? '0 : rr_ptr + FLOW_W'(1);
        end

        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        occ_next   = OCC_W'(count_next) + OCC_W'(accept);
    end

    // Ingress stage, round-robin pointer and ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid   <= 1'b0;
            stage_rpc     <= '0;
            stage_flow    <= '0;
            rr_ptr        <= '0;
            net_ready_out <= 1'b0;
        end else begin
            stage_valid   <= accept;
            net_ready_out <= (occ_next < OCC_W'(DEPTH));
            if (accept) begin
                stage_rpc  <= net_rpc_in;
                stage_flow <= flow_sel;
                if (!lb_mode) begin
                    rr_ptr <= rr_next;
                end
            end
        end
    end

    flow_dispatch_fifo #(
        .DATA_WIDTH (DATA_W),
        .LSIZE      (LFIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push),
        .wr_data   ({stage_rpc, stage_flow}),
        .rd_en     (pop),
        .rd_data_c (fifo_head),
        .count     (fifo_count)
    );

    // Egress register and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpc_out            <= '0;
            rpc_flow_id_out    <= '0;
            rpc_valid_out      <= 1'b0;
            dispatched_cnt_out <= '0;
            drop_cnt_out       <= '0;
        end else begin
            rpc_valid_out <= pop;
            if (pop) begin
                rpc_out            <= fifo_head[DATA_W-1:FLOW_W];
                rpc_flow_id_out    <= fifo_head[FLOW_W-1:0];
                dispatched_cnt_out <= dispatched_cnt_out + 32'd1;
            end
            if (drop) begin
                drop_cnt_out <= drop_cnt_out + 32'd1;
            end
        end
    end

    // Occupancy accounting must keep the stage from writing into a full FIFO.
    always_ff @(posedge clk) begin
        assert (reset || !(push && !pop && fifo_count == CNT_W'(DEPTH)))
            else $error("rpc_flow_dispatcher[%0d]: buffer overflow", NIC_ID);
    end

endmodule
